// File: rtl/id_stage_pkg.sv
// Shared widths, encodings and operand-forwarding helper for the RV32I decode stage.
package id_stage_pkg;

    localparam int ADDR_W     = 32;
    localparam int INSTR_W    = 32;
    localparam int WORD_W     = 32;
    localparam int REG_IDX_W  = 5;
    localparam int ALU_OP_W   = 4;
    localparam int MEM_OP_W   = 4;
    localparam int DEST_SRC_W = 2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [DEST_SRC_W-1:0] {
        DEST_NONE = 2'd0, DEST_ALU = 2'd1, DEST_MEM = 2'd2, DEST_PC4 = 2'd3
    } dest_src_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
        ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR  = 4'd8, ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_NONE = 4'd0, MEM_LB = 4'd1, MEM_LH = 4'd2, MEM_LW = 4'd3, MEM_LBU = 4'd4,
        MEM_LHU  = 4'd5, MEM_SB = 4'd6, MEM_SH = 4'd7, MEM_SW = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
    typedef enum logic       {B_RS2, B_IMM}        b_sel_e;

    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [INSTR_W-1:0]   instr;
        alu_op_e              alu_op;
        logic [WORD_W-1:0]    data_a;
        logic [WORD_W-1:0]    data_b;
        logic [WORD_W-1:0]    imm;
        mem_op_e              mem_op;
        dest_src_e            dest_src;
        logic [REG_IDX_W-1:0] dest_reg;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '{
        pc: '0, instr: '0, alu_op: ALU_ADD, data_a: '0, data_b: '0, imm: '0,
        mem_op: MEM_NONE, dest_src: DEST_NONE, dest_reg: '0
    };

    // alt selects SUB/SRA; the caller decides which funct3 values may use it.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Youngest producer wins; a load in EX cannot forward and is covered by the hazard stall.
    function automatic logic [WORD_W-1:0] fwd_operand(
        input logic [REG_IDX_W-1:0]  rs,
        input logic [REG_IDX_W-1:0]  ex_reg,
        input logic [DEST_SRC_W-1:0] ex_src,
        input logic [WORD_W-1:0]     ex_val,
        input logic [REG_IDX_W-1:0]  me_reg,
        input logic [DEST_SRC_W-1:0] me_src,
        input logic [WORD_W-1:0]     me_val,
        input logic                  wb_en,
        input logic [REG_IDX_W-1:0]  wb_reg,
        input logic [WORD_W-1:0]     wb_val,
        input logic [WORD_W-1:0]     rf_val
    );
        if (rs == '0)                                                       return '0;
        if (ex_reg == rs && (ex_src == DEST_ALU || ex_src == DEST_PC4))     return ex_val;
        if (me_reg == rs && me_src != DEST_NONE)                            return me_val;
        if (wb_en && wb_reg == rs)                                          return wb_val;
        return rf_val;
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 hard zero.
module id_stage_reg_file
    import id_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rf_reset,
    input  logic [REG_IDX_W-1:0] rd_addr_a,
    input  logic [REG_IDX_W-1:0] rd_addr_b,
    output logic [WORD_W-1:0]    rd_data_a,
    output logic [WORD_W-1:0]    rd_data_b,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [WORD_W-1:0]    wr_data
);

    logic [WORD_W-1:0] regs_q [32];
    logic [WORD_W-1:0] regs_d [32];

    // NOTE: regs_d starts as a full copy of regs_q so every element has a value on every path; no latch.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != '0) regs_d[wr_addr] = wr_data;
    end

    // NOTE: this array is a visible, resettable state (the pipeline expects all-zero after rf_reset),
    // so it gets an async clear here instead of being left as an unreset RAM.
    always_ff @(posedge clk or negedge rf_reset) begin
        if (!rf_reset) regs_q <= '{default: '0};
        else           regs_q <= regs_d;
    end

    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, operand fetch with EX/ME/WB forwarding, load-use detection, ID/EX register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rf_reset,
    input  logic                  clr,
    input  logic                  stall,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic [REG_IDX_W-1:0]  i_ex_dest_reg,
    input  logic [DEST_SRC_W-1:0] i_ex_dest_src,
    input  logic [WORD_W-1:0]     i_ex_alu_eval,
    input  logic [REG_IDX_W-1:0]  i_me_dest_reg,
    input  logic [DEST_SRC_W-1:0] i_me_dest_src,
    input  logic [WORD_W-1:0]     i_me_dest_data,
    input  logic                  i_wb_dest_en,
    input  logic [REG_IDX_W-1:0]  i_wb_dest_reg,
    input  logic [WORD_W-1:0]     i_wb_dest_data,
    output logic [ADDR_W-1:0]     o_pc,
    output logic [INSTR_W-1:0]    o_instr,
    output logic [ALU_OP_W-1:0]   o_alu_op,
    output logic [WORD_W-1:0]     o_alu_data_a,
    output logic [WORD_W-1:0]     o_alu_data_b,
    output logic [WORD_W-1:0]     o_imm,
    output logic [MEM_OP_W-1:0]   o_mem_op,
    output logic [DEST_SRC_W-1:0] o_dest_src,
    output logic [REG_IDX_W-1:0]  o_dest_reg,
    output logic                  o_mem_hazard
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [REG_IDX_W-1:0] rs1, rs2, rd;
    logic [WORD_W-1:0]    rf_rs1, rf_rs2, rs1_val, rs2_val;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign rd     = i_instr[11:7];

    id_stage_reg_file u_reg_file (
        .clk       (clk),
        .rf_reset  (rf_reset),
        .rd_addr_a (rs1),
        .rd_addr_b (rs2),
        .rd_data_a (rf_rs1),
        .rd_data_b (rf_rs2),
        .wr_en     (i_wb_dest_en),
        .wr_addr   (i_wb_dest_reg),
        .wr_data   (i_wb_dest_data)
    );

    assign rs1_val = fwd_operand(rs1, i_ex_dest_reg, i_ex_dest_src, i_ex_alu_eval,
                                 i_me_dest_reg, i_me_dest_src, i_me_dest_data,
                                 i_wb_dest_en, i_wb_dest_reg, i_wb_dest_data, rf_rs1);
    assign rs2_val = fwd_operand(rs2, i_ex_dest_reg, i_ex_dest_src, i_ex_alu_eval,
                                 i_me_dest_reg, i_me_dest_src, i_me_dest_data,
                                 i_wb_dest_en, i_wb_dest_reg, i_wb_dest_data, rf_rs2);

    logic      valid, use_rs1, use_rs2;
    alu_op_e   alu_op;
    mem_op_e   mem_op;
    dest_src_e dest_src;
    a_sel_e    a_sel;
    b_sel_e    b_sel;
    logic [WORD_W-1:0] imm;

    always_comb begin
        valid    = 1'b1;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        alu_op   = ALU_ADD;
        mem_op   = MEM_NONE;
        dest_src = DEST_NONE;
        a_sel    = A_RS1;
        b_sel    = B_IMM;
        imm      = '0;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; b_sel = B_RS2; dest_src = DEST_ALU;
                alu_op  = alu_from_f3(funct3, i_instr[30]);
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1; dest_src = DEST_ALU;
                imm     = {{20{i_instr[31]}}, i_instr[31:20]};
                alu_op  = alu_from_f3(funct3, (funct3 == 3'b101) && i_instr[30]);
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; dest_src = DEST_MEM;
                imm     = {{20{i_instr[31]}}, i_instr[31:20]};
                case (funct3)
                    3'b000:  mem_op = MEM_LB;
                    3'b001:  mem_op = MEM_LH;
                    3'b010:  mem_op = MEM_LW;
                    3'b100:  mem_op = MEM_LBU;
                    3'b101:  mem_op = MEM_LHU;
                    default: valid  = 1'b0;
                endcase
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; b_sel = B_RS2;
                imm     = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                case (funct3)
                    3'b000:  mem_op = MEM_SB;
                    3'b001:  mem_op = MEM_SH;
                    3'b010:  mem_op = MEM_SW;
                    default: valid  = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; b_sel = B_RS2;
                imm     = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                case (funct3)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        valid  = 1'b0;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                a_sel    = (opcode == OPC_LUI) ? A_ZERO : A_PC;
                dest_src = DEST_ALU;
                imm      = {i_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                a_sel    = A_PC; dest_src = DEST_PC4;
                imm      = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                use_rs1  = 1'b1; dest_src = DEST_PC4;
                imm      = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            default: valid = 1'b0;
        endcase
    end

    assign o_mem_hazard = (i_ex_dest_src == DEST_MEM) && (i_ex_dest_reg != '0) &&
                          ((use_rs1 && rs1 == i_ex_dest_reg) || (use_rs2 && rs2 == i_ex_dest_reg));

    id_ex_t decoded, id_ex_d, id_ex_q;

    always_comb begin
        decoded          = BUBBLE;
        decoded.pc       = i_pc;
        decoded.instr    = i_instr;
        decoded.alu_op   = alu_op;
        decoded.imm      = imm;
        decoded.mem_op   = mem_op;
        decoded.dest_src = dest_src;
        decoded.dest_reg = (dest_src == DEST_NONE) ? '0 : rd;
        case (a_sel)
            A_PC:    decoded.data_a = i_pc;
            A_ZERO:  decoded.data_a = '0;
            default: decoded.data_a = rs1_val;
        endcase
        decoded.data_b = (b_sel == B_RS2) ? rs2_val : imm;
        if (!valid) decoded = BUBBLE;
    end

    always_comb begin
        id_ex_d = id_ex_q;
        if      (clr)          id_ex_d = BUBBLE;
        else if (stall)        id_ex_d = id_ex_q;
        else if (o_mem_hazard) id_ex_d = BUBBLE;
        else                   id_ex_d = decoded;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rf_reset) begin
        if (!rf_reset) id_ex_q <= BUBBLE;
        else           id_ex_q <= id_ex_d;
    end

    assign o_pc         = id_ex_q.pc;
    assign o_instr      = id_ex_q.instr;
    assign o_alu_op     = id_ex_q.alu_op;
    assign o_alu_data_a = id_ex_q.data_a;
    assign o_alu_data_b = id_ex_q.data_b;
    assign o_imm        = id_ex_q.imm;
    assign o_mem_op     = id_ex_q.mem_op;
    assign o_dest_src   = id_ex_q.dest_src;
    assign o_dest_reg   = id_ex_q.dest_reg;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued as each instruction is driven.
module tb_id_stage;

    logic        clk, rf_reset, clr, stall;
    logic [31:0] i_pc, i_instr;
    logic [4:0]  i_ex_dest_reg, i_me_dest_reg, i_wb_dest_reg;
    logic [1:0]  i_ex_dest_src, i_me_dest_src;
    logic [31:0] i_ex_alu_eval, i_me_dest_data, i_wb_dest_data;
    logic        i_wb_dest_en;
    logic [31:0] o_pc, o_instr, o_alu_data_a, o_alu_data_b, o_imm;
    logic [3:0]  o_alu_op, o_mem_op;
    logic [1:0]  o_dest_src;
    logic [4:0]  o_dest_reg;
    logic        o_mem_hazard;

    id_stage dut (
        .clk(clk), .rf_reset(rf_reset), .clr(clr), .stall(stall),
        .i_pc(i_pc), .i_instr(i_instr),
        .i_ex_dest_reg(i_ex_dest_reg), .i_ex_dest_src(i_ex_dest_src), .i_ex_alu_eval(i_ex_alu_eval),
        .i_me_dest_reg(i_me_dest_reg), .i_me_dest_src(i_me_dest_src), .i_me_dest_data(i_me_dest_data),
        .i_wb_dest_en(i_wb_dest_en), .i_wb_dest_reg(i_wb_dest_reg), .i_wb_dest_data(i_wb_dest_data),
        .o_pc(o_pc), .o_instr(o_instr), .o_alu_op(o_alu_op),
        .o_alu_data_a(o_alu_data_a), .o_alu_data_b(o_alu_data_b), .o_imm(o_imm),
        .o_mem_op(o_mem_op), .o_dest_src(o_dest_src), .o_dest_reg(o_dest_reg),
        .o_mem_hazard(o_mem_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, instr;
        logic [3:0]  alu_op;
        logic [31:0] a, b, imm;
        logic [3:0]  mem_op;
        logic [1:0]  dest_src;
        logic [4:0]  dest_reg;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic [31:0] pc, instr, input logic [3:0] alu,
                                input logic [31:0] a, b, imm, input logic [3:0] mem,
                                input logic [1:0] dsrc, input logic [4:0] rd);
        exp_t e;
        e.pc = pc; e.instr = instr; e.alu_op = alu; e.a = a; e.b = b; e.imm = imm;
        e.mem_op = mem; e.dest_src = dsrc; e.dest_reg = rd;
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, ".pc"},       o_pc,                e.pc);
        check({tag, ".instr"},    o_instr,             e.instr);
        check({tag, ".alu_op"},   32'(o_alu_op),       32'(e.alu_op));
        check({tag, ".a"},        o_alu_data_a,        e.a);
        check({tag, ".b"},        o_alu_data_b,        e.b);
        check({tag, ".imm"},      o_imm,               e.imm);
        check({tag, ".mem_op"},   32'(o_mem_op),       32'(e.mem_op));
        check({tag, ".dest_src"}, 32'(o_dest_src),     32'(e.dest_src));
        check({tag, ".dest_reg"}, 32'(o_dest_reg),     32'(e.dest_reg));
    endtask

    task automatic idle();
        i_ex_dest_reg = 0; i_ex_dest_src = 0; i_ex_alu_eval = 0;
        i_me_dest_reg = 0; i_me_dest_src = 0; i_me_dest_data = 0;
        i_wb_dest_en = 0;  i_wb_dest_reg = 0; i_wb_dest_data = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
        i_pc = pc; i_instr = instr;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        expect_out(tag);
    endtask

    initial begin
        rf_reset = 1'b0; clr = 1'b0; stall = 1'b0;
        drive(0, 0);
        idle();
        repeat (5) @(posedge clk);
        #1;
        sb.push_back(bubble());
        expect_out("reset");
        check("reset.hazard", 32'(o_mem_hazard), 0);
        rf_reset = 1'b1;

        // ADDI x1,x0,-1
        drive(32'h100, 32'hFFF00093);
        sb.push_back(mk(32'h100, 32'hFFF00093, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1));
        step("addi");

        // ADD x6,x5,x0 with same-cycle WB of x5
        i_wb_dest_en = 1; i_wb_dest_reg = 5; i_wb_dest_data = 32'h1234;
        drive(32'h104, 32'h00028333);
        sb.push_back(mk(32'h104, 32'h00028333, 0, 32'h1234, 0, 0, 0, 1, 6));
        step("wb_through");
        idle();

        // ADD x7,x5,x5 from the register file; WB writes x7 meanwhile
        i_wb_dest_en = 1; i_wb_dest_reg = 7; i_wb_dest_data = 32'hCAFE;
        drive(32'h108, 32'h005283B3);
        sb.push_back(mk(32'h108, 32'h005283B3, 0, 32'h1234, 32'h1234, 0, 0, 1, 7));
        step("rf_read");
        idle();

        // ADD x3,x2,x2: EX and ME both hit x2, EX wins; WB writes x1
        i_ex_dest_reg = 2; i_ex_dest_src = 1; i_ex_alu_eval = 7;
        i_me_dest_reg = 2; i_me_dest_src = 1; i_me_dest_data = 9;
        i_wb_dest_en = 1;  i_wb_dest_reg = 1; i_wb_dest_data = 32'h1000;
        drive(32'h10C, 32'h002101B3);
        sb.push_back(mk(32'h10C, 32'h002101B3, 0, 7, 7, 0, 0, 1, 3));
        step("ex_wins");
        idle();

        // SUB x3,x2,x2: EX not writing, ME load result forwards
        i_ex_dest_reg = 2; i_ex_dest_src = 0; i_ex_alu_eval = 7;
        i_me_dest_reg = 2; i_me_dest_src = 2; i_me_dest_data = 9;
        drive(32'h110, 32'h402101B3);
        sb.push_back(mk(32'h110, 32'h402101B3, 1, 9, 9, 0, 0, 1, 3));
        step("me_fwd_sub");
        idle();

        // Load-use: EX loads x4, ADDI x1,x4,1
        i_ex_dest_reg = 4; i_ex_dest_src = 2;
        drive(32'h114, 32'h00120093);
        #1;
        check("hazard_rs1", 32'(o_mem_hazard), 1);
        sb.push_back(bubble());
        step("hazard_bubble");

        // Same case with EX rd = x0: no hazard, decode proceeds
        i_ex_dest_reg = 0;
        drive(32'h118, 32'h00120093);
        #1;
        check("hazard_x0", 32'(o_mem_hazard), 0);
        sb.push_back(mk(32'h118, 32'h00120093, 0, 0, 1, 1, 0, 1, 1));
        step("no_hazard_x0");

        // ADDI x1,x0,4: rs2 field equals EX load dest but is unused
        i_ex_dest_reg = 4;
        drive(32'h11C, 32'h00400093);
        #1;
        check("hazard_unused_rs2", 32'(o_mem_hazard), 0);
        sb.push_back(mk(32'h11C, 32'h00400093, 0, 0, 4, 4, 0, 1, 1));
        step("addi_imm4");

        // Store data register is a real rs2 use
        i_ex_dest_reg = 7;
        drive(32'h120, 32'h0070A423);
        #1;
        check("hazard_rs2", 32'(o_mem_hazard), 1);
        idle();

        // Flush during a valid instruction
        clr = 1'b1;
        drive(32'h120, 32'hFFF00093);
        sb.push_back(bubble());
        step("clr");
        clr = 1'b0;

        // SW x7,8(x1)
        drive(32'h124, 32'h0070A423);
        sb.push_back(mk(32'h124, 32'h0070A423, 0, 32'h1000, 32'hCAFE, 8, 8, 0, 0));
        step("sw");

        // Stall with a new instruction presented: outputs hold
        stall = 1'b1;
        drive(32'h128, 32'h123454B7);
        sb.push_back(mk(32'h124, 32'h0070A423, 0, 32'h1000, 32'hCAFE, 8, 8, 0, 0));
        step("stall");
        stall = 1'b0;

        // BLT x1,x7,-4
        drive(32'h12C, 32'hFE70CEE3);
        sb.push_back(mk(32'h12C, 32'hFE70CEE3, 3, 32'h1000, 32'hCAFE, 32'hFFFF_FFFC, 0, 0, 0));
        step("blt");

        // LUI x9,0x12345
        drive(32'h130, 32'h123454B7);
        sb.push_back(mk(32'h130, 32'h123454B7, 0, 0, 32'h1234_5000, 32'h1234_5000, 0, 1, 9));
        step("lui");

        // JAL x1,+8
        drive(32'h134, 32'h008000EF);
        sb.push_back(mk(32'h134, 32'h008000EF, 0, 32'h134, 8, 8, 0, 3, 1));
        step("jal");

        // LW x10,4(x5)
        drive(32'h138, 32'h0042A503);
        sb.push_back(mk(32'h138, 32'h0042A503, 0, 32'h1234, 4, 4, 3, 2, 10));
        step("lw");

        // JALR x1,0(x5) with EX producing x5 as PC+4
        i_ex_dest_reg = 5; i_ex_dest_src = 3; i_ex_alu_eval = 32'h200;
        drive(32'h13C, 32'h000280E7);
        sb.push_back(mk(32'h13C, 32'h000280E7, 0, 32'h200, 0, 0, 0, 3, 1));
        step("jalr_pc4_fwd");
        idle();

        // Unknown opcode
        drive(32'h140, 32'hFFFF_FFFF);
        sb.push_back(bubble());
        step("unknown");

        // WB to x0 must neither forward nor write
        i_wb_dest_en = 1; i_wb_dest_reg = 0; i_wb_dest_data = 32'hDEAD;
        drive(32'h144, 32'h00000333);
        sb.push_back(mk(32'h144, 32'h00000333, 0, 0, 0, 0, 0, 1, 6));
        step("x0_wb");
        idle();

        // Asynchronous reset between edges
        #2;
        rf_reset = 1'b0;
        #1;
        sb.push_back(bubble());
        expect_out("async_reset");
        #1;
        rf_reset = 1'b1;
        drive(32'h148, 32'h005283B3);
        sb.push_back(mk(32'h148, 32'h005283B3, 0, 0, 0, 0, 0, 1, 7));
        step("rf_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
